jacaranda_wb_slave: RTL and testbench

- Wishbone classic-cycle responder between the Caravel management SoC (initiator) and the jacaranda-8 core.
- Acknowledges every bus cycle in its window. Gives the host read and write access to instruction memory and data memory, plus a small register file holding the CPU reset/run control and a PC readback.
- Replaces the un-acked, always-writing instruction-memory load path in the computer top.

---
 rtl/jacaranda_wb_slave_if.sv | 22 ++
 rtl/jacaranda_wb_slave.sv | 137 +++++++++++++
 tb/tb_jacaranda_wb_slave.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jacaranda_wb_slave_if.sv
// Wishbone classic-cycle bus bundle between the management SoC and the
// jacaranda-8 responder.
interface jacaranda_wb_slave_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/jacaranda_wb_slave.sv
// Wishbone responder giving the host access to jacaranda-8 instruction memory,
// data memory and a small control register file (CPU reset, PC readback).
//
// state | meaning
// IDLE  | waiting for a hit in the window
// RD    | memory is returning data for the latched read; ack follows if still strobed
// ACK   | ack (and any write pulse) high for this one cycle
module jacaranda_wb_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter logic [7:0]  SCRATCH_RST = 8'h00
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    jacaranda_wb_slave_if.slave        wbs,
    output logic [7:0]                 imem_addr,
    output logic [7:0]                 imem_w_data,
    output logic                       imem_w_en,
    input  logic [7:0]                 imem_r_data,
    output logic [7:0]                 dmem_addr,
    output logic [7:0]                 dmem_w_data,
    output logic                       dmem_w_en,
    input  logic [7:0]                 dmem_r_data,
    input  logic [7:0]                 cpu_pc,
    output logic                       cpu_reset
);

    typedef enum logic [1:0] {IDLE, RD, ACK} state_t;

    localparam logic [1:0] RGN_IMEM = 2'b00;
    localparam logic [1:0] RGN_DMEM = 2'b01;
    localparam logic [1:0] RGN_REG  = 2'b10;

    localparam logic [1:0] OFF_CTRL    = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;
    localparam logic [1:0] OFF_SCRATCH = 2'd2;

    state_t      state;
    logic        ctrl;
    logic [7:0]  scratch;
    logic [1:0]  rd_region;
    logic [1:0]  rd_off;
    logic        ack_q;
    logic [8:0]  dat_q;
    logic [8:0]  rd_mux;
    logic        hit;
    logic        strobed;
    logic [1:0]  region;
    logic [1:0]  reg_off;
    logic        unused_bits;

    assign strobed = wbs.wbs_cyc_i & wbs.wbs_stb_i;
    assign hit     = strobed & (wbs.wbs_adr_i[31:12] == BASE_ADDR[31:12]);
    assign region  = wbs.wbs_adr_i[11:10];
    assign reg_off = wbs.wbs_adr_i[3:2];

    assign imem_addr   = wbs.wbs_adr_i[9:2];
    assign dmem_addr   = wbs.wbs_adr_i[9:2];
    assign imem_w_data = wbs.wbs_dat_i[7:0];
    assign dmem_w_data = wbs.wbs_dat_i[7:0];

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = {23'b0, dat_q};
    assign cpu_reset     = ctrl;

    // Only byte lane 0 and word-aligned addresses carry meaning.
    assign unused_bits = ^{wbs.wbs_sel_i[3:1], wbs.wbs_adr_i[1:0], wbs.wbs_dat_i[31:8]};

    // Read data selected by the region/offset latched when the read was accepted.
    always_comb begin
        rd_mux = 9'd0;
        case (rd_region)
            RGN_IMEM: rd_mux = {1'b0, imem_r_data};
            RGN_DMEM: rd_mux = {1'b0, dmem_r_data};
            RGN_REG: begin
                case (rd_off)
                    OFF_CTRL:    rd_mux = {8'd0, ctrl};
                    OFF_STATUS:  rd_mux = {~ctrl, cpu_pc};
                    OFF_SCRATCH: rd_mux = {1'b0, scratch};
                    default:     rd_mux = 9'd0;
                endcase
            end
            default: rd_mux = 9'd0;
        endcase
    end

    // Bus FSM with registered ack, read data, write pulses and control registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            ack_q     <= 1'b0;
            dat_q     <= 9'd0;
            imem_w_en <= 1'b0;
            dmem_w_en <= 1'b0;
            ctrl      <= 1'b1;
            scratch   <= SCRATCH_RST;
            rd_region <= 2'b00;
            rd_off    <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (hit && wbs.wbs_we_i) begin
                        state <= ACK;
                        ack_q <= 1'b1;
                        if (wbs.wbs_sel_i[0]) begin
                            // Memory writes are only allowed while the CPU is held.
                            if (region == RGN_IMEM && ctrl) imem_w_en <= 1'b1;
                            if (region == RGN_DMEM && ctrl) dmem_w_en <= 1'b1;
                            if (region == RGN_REG && reg_off == OFF_CTRL)    ctrl    <= wbs.wbs_dat_i[0];
                            if (region == RGN_REG && reg_off == OFF_SCRATCH) scratch <= wbs.wbs_dat_i[7:0];
                        end
                    end else if (hit) begin
                        state     <= RD;
                        rd_region <= region;
                        rd_off    <= reg_off;
                    end
                end
                RD: begin
                    if (strobed) begin
                        dat_q <= rd_mux;
                        ack_q <= 1'b1;
                        state <= ACK;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACK: begin
                    ack_q     <= 1'b0;
                    imem_w_en <= 1'b0;
                    dmem_w_en <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jacaranda_wb_slave.sv
// Bench for jacaranda_wb_slave: directed vector table, hand sequences for
// abort and mid-cycle reset, then random traffic against a behavioural model.
module tb_jacaranda_wb_slave;

    logic       wb_clk_i = 1'b0;
    logic       wb_rst_i = 1'b1;
    logic [7:0] imem_addr, imem_w_data, dmem_addr, dmem_w_data;
    logic       imem_w_en, dmem_w_en, cpu_reset;
    logic [7:0] imem_r_data, dmem_r_data;
    logic [7:0] cpu_pc = 8'h42;
    logic       init_mem = 1'b1;

    int checks = 0;
    int errors = 0;

    jacaranda_wb_slave_if wbs ();

    jacaranda_wb_slave dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .wbs         (wbs.slave),
        .imem_addr   (imem_addr),
        .imem_w_data (imem_w_data),
        .imem_w_en   (imem_w_en),
        .imem_r_data (imem_r_data),
        .dmem_addr   (dmem_addr),
        .dmem_w_data (dmem_w_data),
        .dmem_w_en   (dmem_w_en),
        .dmem_r_data (dmem_r_data),
        .cpu_pc      (cpu_pc),
        .cpu_reset   (cpu_reset)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    function automatic logic [7:0] imem_init(input int i);
        return 8'(i) ^ 8'h5A;
    endfunction

    function automatic logic [7:0] dmem_init(input int i);
        return ~8'(i);
    endfunction

    // Synchronous-read memories standing in for the core's IMEM/DMEM.
    logic [7:0] imem_arr [256];
    logic [7:0] dmem_arr [256];
    always @(posedge wb_clk_i) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) begin
                imem_arr[i] <= imem_init(i);
                dmem_arr[i] <= dmem_init(i);
            end
        end else begin
            if (imem_w_en) imem_arr[imem_addr] <= imem_w_data;
            if (dmem_w_en) dmem_arr[dmem_addr] <= dmem_w_data;
        end
        imem_r_data <= imem_arr[imem_addr];
        dmem_r_data <= dmem_arr[dmem_addr];
    end

    // Behavioural model of the host-visible state.
    logic       m_ctrl;
    logic [7:0] m_scratch;
    logic [7:0] m_imem [256];
    logic [7:0] m_dmem [256];

    // Returns ack latency (0 = no response), read data and write pulse counts.
    function automatic void model_access(input logic [31:0] adr, input logic we,
                                         input logic [31:0] dat, input logic [3:0] sel,
                                         output int lat, output logic [31:0] rd,
                                         output int iw, output int dw);
        int idx;
        int rgn;
        int off;
        idx = int'(adr[9:2]);
        rgn = int'(adr[11:10]);
        off = int'(adr[3:2]);
        lat = 0; rd = 32'd0; iw = 0; dw = 0;
        if (adr[31:12] != 20'h30000) return;
        if (we) begin
            lat = 1;
            if (sel[0]) begin
                if (rgn == 0 && m_ctrl) begin m_imem[idx] = dat[7:0]; iw = 1; end
                if (rgn == 1 && m_ctrl) begin m_dmem[idx] = dat[7:0]; dw = 1; end
                if (rgn == 2 && off == 0) m_ctrl = dat[0];
                if (rgn == 2 && off == 2) m_scratch = dat[7:0];
            end
        end else begin
            lat = 2;
            if (rgn == 0) rd = {24'd0, m_imem[idx]};
            else if (rgn == 1) rd = {24'd0, m_dmem[idx]};
            else if (rgn == 2) begin
                if (off == 0) rd = {31'd0, m_ctrl};
                else if (off == 1) rd = {23'd0, ~m_ctrl, cpu_pc};
                else if (off == 2) rd = {24'd0, m_scratch};
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle_bus();
        wbs.wbs_cyc_i = 1'b0;
        wbs.wbs_stb_i = 1'b0;
        wbs.wbs_we_i  = 1'b0;
    endtask

    // One classic cycle; waits up to 10 cycles for ack, then checks ack fell.
    task automatic do_access(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                             input logic [3:0] sel, output int lat, output logic [31:0] rd,
                             output int iw, output int dw, output logic ack_after);
        @(negedge wb_clk_i);
        wbs.wbs_adr_i = adr;
        wbs.wbs_dat_i = dat;
        wbs.wbs_sel_i = sel;
        wbs.wbs_we_i  = we;
        wbs.wbs_cyc_i = 1'b1;
        wbs.wbs_stb_i = 1'b1;
        lat = 0; rd = 32'd0; iw = 0; dw = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge wb_clk_i);
            iw += int'(imem_w_en);
            dw += int'(dmem_w_en);
            if (wbs.wbs_ack_o) begin
                lat = i;
                rd  = wbs.wbs_dat_o;
                break;
            end
        end
        idle_bus();
        @(negedge wb_clk_i);
        iw += int'(imem_w_en);
        dw += int'(dmem_w_en);
        ack_after = wbs.wbs_ack_o;
    endtask

    typedef struct {
        string       name;
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          lat;
        logic [31:0] rd;
        int          iw;
        int          dw;
    } vec_t;

    vec_t vecs [$];

    initial begin
        int          lat, iw, dw, e_lat, e_iw, e_dw;
        logic [31:0] rd, e_rd, prev_dat;
        logic        ack_after;

        for (int i = 0; i < 256; i++) begin
            m_imem[i] = imem_init(i);
            m_dmem[i] = dmem_init(i);
        end
        m_ctrl    = 1'b1;
        m_scratch = 8'h00;

        vecs.push_back('{"rd_ctrl_reset",   32'h3000_0800, 1'b0, 32'h0,   4'h0, 2, 32'h1,   0, 0});
        vecs.push_back('{"wr_imem5",        32'h3000_0014, 1'b1, 32'hA5,  4'h1, 1, 32'h0,   1, 0});
        vecs.push_back('{"rd_imem5",        32'h3000_0014, 1'b0, 32'h0,   4'h1, 2, 32'hA5,  0, 0});
        vecs.push_back('{"wr_ctrl0",        32'h3000_0800, 1'b1, 32'h0,   4'h1, 1, 32'h0,   0, 0});
        vecs.push_back('{"wr_dmem_guarded", 32'h3000_0410, 1'b1, 32'h3C,  4'h1, 1, 32'h0,   0, 0});
        vecs.push_back('{"rd_dmem_kept",    32'h3000_0410, 1'b0, 32'h0,   4'h1, 2, 32'hFB,  0, 0});
        vecs.push_back('{"rd_status_run",   32'h3000_0804, 1'b0, 32'h0,   4'h1, 2, 32'h142, 0, 0});
        vecs.push_back('{"wr_scratch",      32'h3000_0808, 1'b1, 32'h1FF, 4'h1, 1, 32'h0,   0, 0});
        vecs.push_back('{"rd_scratch",      32'h3000_0808, 1'b0, 32'h0,   4'h1, 2, 32'hFF,  0, 0});
        vecs.push_back('{"wr_unmapped",     32'h3000_0C00, 1'b1, 32'h77,  4'h1, 1, 32'h0,   0, 0});
        vecs.push_back('{"rd_unmapped",     32'h3000_0C00, 1'b0, 32'h0,   4'h1, 2, 32'h0,   0, 0});
        vecs.push_back('{"wr_ctrl1",        32'h3000_0800, 1'b1, 32'h1,   4'h1, 1, 32'h0,   0, 0});
        vecs.push_back('{"rd_status_held",  32'h3000_0804, 1'b0, 32'h0,   4'h1, 2, 32'h042, 0, 0});
        vecs.push_back('{"wr_dmem_sel0",    32'h3000_0410, 1'b1, 32'h11,  4'hE, 1, 32'h0,   0, 0});
        vecs.push_back('{"rd_dmem_sel0",    32'h3000_0410, 1'b0, 32'h0,   4'h1, 2, 32'hFB,  0, 0});
        vecs.push_back('{"wr_dmem4",        32'h3000_0410, 1'b1, 32'h3C,  4'h1, 1, 32'h0,   0, 1});
        vecs.push_back('{"rd_dmem4",        32'h3000_0410, 1'b0, 32'h0,   4'h1, 2, 32'h3C,  0, 0});
        vecs.push_back('{"wr_reg3",         32'h3000_080C, 1'b1, 32'hFF,  4'h1, 1, 32'h0,   0, 0});
        vecs.push_back('{"rd_reg3",         32'h3000_080C, 1'b0, 32'h0,   4'h1, 2, 32'h0,   0, 0});
        vecs.push_back('{"wr_ctrl_sel0",    32'h3000_0800, 1'b1, 32'h0,   4'h0, 1, 32'h0,   0, 0});
        vecs.push_back('{"rd_ctrl_still1",  32'h3000_0800, 1'b0, 32'h0,   4'h1, 2, 32'h1,   0, 0});
        vecs.push_back('{"rd_miss",         32'h3000_1000, 1'b0, 32'h0,   4'h1, 0, 32'h0,   0, 0});
        vecs.push_back('{"wr_miss",         32'h2000_0014, 1'b1, 32'h55,  4'h1, 0, 32'h0,   0, 0});

        idle_bus();
        wbs.wbs_sel_i = 4'h0;
        wbs.wbs_adr_i = 32'h0;
        wbs.wbs_dat_i = 32'h0;
        repeat (3) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        init_mem = 1'b0;
        @(negedge wb_clk_i);

        chk("reset_ack", {31'd0, wbs.wbs_ack_o}, 32'd0);
        chk("reset_dat", wbs.wbs_dat_o, 32'd0);
        chk("reset_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("reset_wen", {30'd0, imem_w_en, dmem_w_en}, 32'd0);

        // Address/data fan-out to the memories is combinational from the bus.
        wbs.wbs_adr_i = 32'h3000_0014;
        wbs.wbs_dat_i = 32'h1234_56A5;
        #1;
        chk("imem_addr", {24'd0, imem_addr}, 32'h5);
        chk("imem_w_data", {24'd0, imem_w_data}, 32'hA5);
        chk("dmem_addr", {24'd0, dmem_addr}, 32'h5);
        chk("dmem_w_data", {24'd0, dmem_w_data}, 32'hA5);

        foreach (vecs[k]) begin
            model_access(vecs[k].adr, vecs[k].we, vecs[k].dat, vecs[k].sel, e_lat, e_rd, e_iw, e_dw);
            do_access(vecs[k].adr, vecs[k].we, vecs[k].dat, vecs[k].sel, lat, rd, iw, dw, ack_after);
            chk({vecs[k].name, "_lat"}, lat, vecs[k].lat);
            if (!vecs[k].we && vecs[k].lat != 0) chk({vecs[k].name, "_data"}, rd, vecs[k].rd);
            chk({vecs[k].name, "_imem_wen"}, iw, vecs[k].iw);
            chk({vecs[k].name, "_dmem_wen"}, dw, vecs[k].dw);
            chk({vecs[k].name, "_ack_pulse"}, {31'd0, ack_after}, 32'd0);
        end

        // Abort: strobe dropped while in RD gives no ack and leaves dat_o alone.
        prev_dat = wbs.wbs_dat_o;
        @(negedge wb_clk_i);
        wbs.wbs_adr_i = 32'h3000_0808;
        wbs.wbs_we_i  = 1'b0;
        wbs.wbs_cyc_i = 1'b1;
        wbs.wbs_stb_i = 1'b1;
        @(negedge wb_clk_i);
        wbs.wbs_stb_i = 1'b0;
        lat = 0;
        repeat (4) begin
            @(negedge wb_clk_i);
            if (wbs.wbs_ack_o) lat++;
        end
        idle_bus();
        chk("abort_no_ack", lat, 0);
        chk("abort_dat_held", wbs.wbs_dat_o, prev_dat);
        model_access(32'h3000_0804, 1'b0, 32'h0, 4'h1, e_lat, e_rd, e_iw, e_dw);
        do_access(32'h3000_0804, 1'b0, 32'h0, 4'h1, lat, rd, iw, dw, ack_after);
        chk("after_abort_lat", lat, e_lat);
        chk("after_abort_data", rd, e_rd);

        // Reset while acking a CTRL=0 write.
        @(negedge wb_clk_i);
        wbs.wbs_adr_i = 32'h3000_0800;
        wbs.wbs_dat_i = 32'h0;
        wbs.wbs_sel_i = 4'h1;
        wbs.wbs_we_i  = 1'b1;
        wbs.wbs_cyc_i = 1'b1;
        wbs.wbs_stb_i = 1'b1;
        @(posedge wb_clk_i);
        #1;
        chk("mid_rst_ack_before", {31'd0, wbs.wbs_ack_o}, 32'd1);
        chk("mid_rst_ctrl_written", {31'd0, cpu_reset}, 32'd0);
        wb_rst_i = 1'b1;
        #1;
        chk("mid_rst_ack_drop", {31'd0, wbs.wbs_ack_o}, 32'd0);
        chk("mid_rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        idle_bus();
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        m_ctrl    = 1'b1;
        m_scratch = 8'h00;
        chk("mid_rst_dat", wbs.wbs_dat_o, 32'd0);

        // Reset while an IMEM write pulse is high: pulse drops, write discarded.
        @(negedge wb_clk_i);
        wbs.wbs_adr_i = 32'h3000_0020;
        wbs.wbs_dat_i = 32'hC3;
        wbs.wbs_sel_i = 4'h1;
        wbs.wbs_we_i  = 1'b1;
        wbs.wbs_cyc_i = 1'b1;
        wbs.wbs_stb_i = 1'b1;
        @(posedge wb_clk_i);
        #1;
        chk("mid_rst_wen_before", {31'd0, imem_w_en}, 32'd1);
        wb_rst_i = 1'b1;
        #1;
        chk("mid_rst_wen_drop", {31'd0, imem_w_en}, 32'd0);
        idle_bus();
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        model_access(32'h3000_0020, 1'b0, 32'h0, 4'h1, e_lat, e_rd, e_iw, e_dw);
        do_access(32'h3000_0020, 1'b0, 32'h0, 4'h1, lat, rd, iw, dw, ack_after);
        chk("mid_rst_imem_kept", rd, e_rd);

        // Random traffic against the model.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] adr, dat;
            logic [3:0]  sel;
            logic        we;
            int          pick;
            pick = int'($urandom_range(0, 9));
            adr  = 32'h3000_0000 | ($urandom & 32'h0000_0FFC);
            if (pick == 0) begin
                adr = $urandom;
                if (adr[31:12] == 20'h30000) adr[31] = 1'b1;
            end else if (pick <= 2) begin
                adr = 32'h3000_0800;
            end
            we     = 1'($urandom);
            dat    = $urandom;
            sel    = 4'($urandom);
            cpu_pc = 8'($urandom);
            model_access(adr, we, dat, sel, e_lat, e_rd, e_iw, e_dw);
            do_access(adr, we, dat, sel, lat, rd, iw, dw, ack_after);
            chk("rand_lat", lat, e_lat);
            if (!we && e_lat != 0) chk("rand_data", rd, e_rd);
            chk("rand_imem_wen", iw, e_iw);
            chk("rand_dmem_wen", dw, e_dw);
            chk("rand_ack_pulse", {31'd0, ack_after}, 32'd0);
            chk("rand_cpu_reset", {31'd0, cpu_reset}, {31'd0, m_ctrl});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
